// File: rtl/ram16_port_ctrl.sv
// ram16_port_ctrl: arbitrates a fetch port and a load/store port onto one 16-bit-word RAM port.
// Define RAM16_ARB_RR_EN for round-robin tie-breaking; otherwise the data port wins ties.
module ram16_port_ctrl #(
    parameter int MEM_WIDTH = 65536,
    localparam int RAM_AW = $clog2(MEM_WIDTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_req_i,
    input  logic [RAM_AW:0]   i_addr_i,
    output logic              i_gnt_o,
    output logic              i_rvalid_o,
    output logic [31:0]       i_rdata_o,
    input  logic              d_req_i,
    input  logic              d_we_i,
    input  logic [3:0]        d_be_i,
    input  logic [RAM_AW:0]   d_addr_i,
    input  logic [31:0]       d_wdata_i,
    output logic              d_gnt_o,
    output logic              d_rvalid_o,
    output logic [31:0]       d_rdata_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [31:0]       ram_data_o,
    input  logic [31:0]       ram_data_a_i,
    input  logic [31:0]       ram_data_b_i
);
    typedef enum logic [1:0] {IDLE, RMW_MERGE, WR_HI} state_t;
    state_t            r_state, w_next;
    logic [RAM_AW-1:0] r_hw, w_d_hw;
    logic [3:0]        r_be;
    logic [31:0]       r_wdata, w_old, w_merged;
    logic [15:0]       r_hi;
    logic              r_i_rvalid, r_d_rvalid, r_d_load;
    logic              w_idle, w_i_gnt, w_d_gnt, w_store_done;
    logic              w_full, w_lo, w_hi, w_wr1;
    logic              w_unused;

    function automatic logic [RAM_AW-1:0] f_inc(input logic [RAM_AW-1:0] hw);
        return (hw == RAM_AW'(MEM_WIDTH - 1)) ? '0 : hw + RAM_AW'(1);
    endfunction

    // Gating with reset_n keeps every combinational output low while reset is held.
    assign w_idle = (r_state == IDLE) && reset_n;
`ifdef RAM16_ARB_RR_EN
    logic r_ptr;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_ptr <= 1'b0;
        else if (w_i_gnt || w_d_gnt) r_ptr <= w_i_gnt;
    end
    assign w_d_gnt = w_idle && d_req_i && (!i_req_i || r_ptr);
`else
    assign w_d_gnt = w_idle && d_req_i;
`endif
    assign w_i_gnt = w_idle && i_req_i && !w_d_gnt;

    assign w_d_hw   = d_addr_i[RAM_AW:1];
    assign w_old    = {ram_data_b_i[15:0], ram_data_a_i[15:0]};
    assign w_full   = d_be_i == 4'hF;
    assign w_lo     = d_be_i == 4'h3;
    assign w_hi     = d_be_i == 4'hC;
    assign w_wr1    = w_full || w_lo || w_hi;
    assign w_unused = ^{i_addr_i[0], d_addr_i[0], ram_data_a_i[31:16], ram_data_b_i[31:16]};

    always_comb begin
        w_merged = w_old;
        for (int k = 0; k < 4; k++) if (r_be[k]) w_merged[8*k +: 8] = r_wdata[8*k +: 8];
    end

    always_comb begin
        w_next       = r_state;
        ram_en_o     = 1'b0;
        ram_we_o     = 1'b0;
        ram_addr_o   = '0;
        ram_data_o   = '0;
        w_store_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_i_gnt) begin
                    ram_en_o   = 1'b1;
                    ram_addr_o = i_addr_i[RAM_AW:1];
                end else if (w_d_gnt && d_we_i && d_be_i != 4'h0) begin
                    // Aligned halves write straight away; anything else reads first for the merge.
                    ram_en_o     = 1'b1;
                    ram_we_o     = w_wr1;
                    ram_addr_o   = w_hi ? f_inc(w_d_hw) : w_d_hw;
                    ram_data_o   = {16'h0, w_hi ? d_wdata_i[31:16] : (w_wr1 ? d_wdata_i[15:0] : 16'h0)};
                    w_next       = w_full ? WR_HI : (w_wr1 ? IDLE : RMW_MERGE);
                    w_store_done = w_lo || w_hi;
                end else if (w_d_gnt) begin
                    ram_en_o     = !d_we_i;
                    ram_addr_o   = d_we_i ? '0 : w_d_hw;
                    w_store_done = d_we_i;
                end
            end
            RMW_MERGE: begin
                ram_en_o     = 1'b1;
                ram_we_o     = 1'b1;
                ram_addr_o   = (r_be[1:0] != 2'b00) ? r_hw : f_inc(r_hw);
                ram_data_o   = {16'h0, (r_be[1:0] != 2'b00) ? w_merged[15:0] : w_merged[31:16]};
                w_next       = (r_be[1:0] != 2'b00 && r_be[3:2] != 2'b00) ? WR_HI : IDLE;
                w_store_done = !(r_be[1:0] != 2'b00 && r_be[3:2] != 2'b00);
            end
            WR_HI: begin
                ram_en_o     = 1'b1;
                ram_we_o     = 1'b1;
                ram_addr_o   = f_inc(r_hw);
                ram_data_o   = {16'h0, r_hi};
                w_next       = IDLE;
                w_store_done = 1'b1;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_hw       <= '0;
            r_be       <= '0;
            r_wdata    <= '0;
            r_hi       <= '0;
            r_i_rvalid <= 1'b0;
            r_d_rvalid <= 1'b0;
            r_d_load   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_i_rvalid <= w_i_gnt;
            r_d_rvalid <= (w_d_gnt && !d_we_i) || w_store_done;
            if (w_d_gnt) begin
                r_d_load <= !d_we_i;
                r_hw     <= w_d_hw;
                r_be     <= d_be_i;
                r_wdata  <= d_wdata_i;
                r_hi     <= d_wdata_i[31:16];
            end else if (r_state == RMW_MERGE) begin
                r_hi <= w_merged[31:16];
            end
        end
    end

    assign i_gnt_o    = w_i_gnt;
    assign d_gnt_o    = w_d_gnt;
    assign i_rvalid_o = r_i_rvalid;
    assign d_rvalid_o = r_d_rvalid;
    assign i_rdata_o  = r_i_rvalid ? w_old : '0;
    assign d_rdata_o  = (r_d_rvalid && r_d_load) ? w_old : '0;
endmodule

// File: tb/tb_ram16_port_ctrl.sv
// tb_ram16_port_ctrl: directed and random checks of ram16_port_ctrl against a shadow-memory model.
module tb_ram16_port_ctrl;
    localparam int MW = 65536;
    localparam int AW = 16;
`ifdef RAM16_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          tb_clr = 1'b0;
    logic          i_req_i = 1'b0;
    logic [AW:0]   i_addr_i = '0;
    logic          i_gnt_o, i_rvalid_o;
    logic [31:0]   i_rdata_o;
    logic          d_req_i = 1'b0, d_we_i = 1'b0;
    logic [3:0]    d_be_i = '0;
    logic [AW:0]   d_addr_i = '0;
    logic [31:0]   d_wdata_i = '0;
    logic          d_gnt_o, d_rvalid_o;
    logic [31:0]   d_rdata_o;
    logic          ram_en_o, ram_we_o;
    logic [AW-1:0] ram_addr_o;
    logic [31:0]   ram_data_o, ram_data_a_i, ram_data_b_i;
    logic [15:0]   mem [MW];
    logic [15:0]   ref_mem [MW];
    int            n_chk = 0, n_fail = 0;

    ram16_port_ctrl #(.MEM_WIDTH(MW)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_req_i(i_req_i), .i_addr_i(i_addr_i), .i_gnt_o(i_gnt_o), .i_rvalid_o(i_rvalid_o), .i_rdata_o(i_rdata_o),
        .d_req_i(d_req_i), .d_we_i(d_we_i), .d_be_i(d_be_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
        .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
        .ram_en_o(ram_en_o), .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
        .ram_data_a_i(ram_data_a_i), .ram_data_b_i(ram_data_b_i)
    );

    always #5 clk = ~clk;

    // Simulation RAM: registered dual-word read, upper output bits carry junk the DUT must ignore.
    always @(posedge clk) begin
        if (tb_clr) begin
            for (int k = 0; k < MW; k++) mem[k] <= 16'(k * 7919 + 4660);
            ram_data_a_i <= '0;
            ram_data_b_i <= '0;
        end else if (ram_en_o && ram_we_o) begin
            mem[ram_addr_o] <= ram_data_o[15:0];
        end else if (ram_en_o) begin
            ram_data_a_i <= {16'hA5A5, mem[ram_addr_o]};
            ram_data_b_i <= {16'h5A5A, mem[ram_addr_o + 16'd1]};
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [AW:0] a);
        logic [15:0] h, h1;
        h  = a[AW:1];
        h1 = h + 16'd1;
        return {ref_mem[h1], ref_mem[h]};
    endfunction

    task automatic do_load(input bit port_d, input logic [AW:0] a, output logic [31:0] got);
        logic [31:0] expv;
        expv = ref_rd(a);
        if (port_d) begin
            d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = a;
            d_be_i = 4'($urandom); d_wdata_i = $urandom;
        end else begin
            i_req_i = 1'b1; i_addr_i = a;
        end
        #1;
        chk(port_d ? "ld_d_gnt" : "ld_i_gnt", 32'({i_gnt_o, d_gnt_o}), port_d ? 32'h1 : 32'h2);
        chk("ld_ram_en_we", 32'({ram_en_o, ram_we_o}), 32'h2);
        chk("ld_ram_addr", 32'(ram_addr_o), 32'(a[AW:1]));
        @(posedge clk); #1;
        i_req_i = 1'b0; d_req_i = 1'b0;
        i_addr_i = 17'($urandom); d_addr_i = 17'($urandom);
        #1;
        chk("ld_rvalid", 32'({i_rvalid_o, d_rvalid_o}), port_d ? 32'h1 : 32'h2);
        got = port_d ? d_rdata_o : i_rdata_o;
        chk("ld_rdata", got, expv);
        chk("ld_other_rdata", port_d ? i_rdata_o : d_rdata_o, 32'h0);
    endtask

    task automatic do_store(input logic [AW:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [15:0] h, h1;
        bit partial;
        int occ, nwr, nrd, wr, rd;
        h  = a[AW:1];
        h1 = h + 16'd1;
        partial = !(be == 4'h0 || be == 4'h3 || be == 4'hC || be == 4'hF);
        nwr = int'(be[1:0] != 2'b00) + int'(be[3:2] != 2'b00);
        nrd = int'(partial);
        occ = (be == 4'hF || (partial && nwr == 1)) ? 2 : (partial ? 3 : 1);
        wr = 0; rd = 0;
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = be; d_addr_i = a; d_wdata_i = wd;
        #1;
        chk("st_gnt", 32'({i_gnt_o, d_gnt_o}), 32'h1);
        for (int c = 0; c < occ; c++) begin
            if (c > 0) begin
                chk("st_busy_gnt", 32'({i_gnt_o, d_gnt_o}), 32'h0);
                chk("st_busy_rvalid", 32'(d_rvalid_o), 32'h0);
            end
            wr += int'(ram_en_o & ram_we_o);
            rd += int'(ram_en_o & ~ram_we_o);
            @(posedge clk); #1;
            d_req_i = 1'b0; d_be_i = 4'($urandom); d_addr_i = 17'($urandom); d_wdata_i = $urandom;
            i_req_i = (c < occ - 1);
            i_addr_i = 17'($urandom);
            #1;
        end
        chk("st_rvalid", 32'({d_rvalid_o, i_rvalid_o}), 32'h2);
        chk("st_rdata", d_rdata_o, 32'h0);
        chk("st_writes", wr, nwr);
        chk("st_reads", rd, nrd);
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                logic [15:0] t;
                t = h + 16'(k / 2);
                ref_mem[t][8*(k%2) +: 8] = wd[8*k +: 8];
            end
        end
        chk("st_mem_lo", 32'(mem[h]), 32'(ref_mem[h]));
        chk("st_mem_hi", 32'(mem[h1]), 32'(ref_mem[h1]));
    endtask

    task automatic chk_quiet(input string tag);
        chk(tag, 32'({i_gnt_o, d_gnt_o, i_rvalid_o, d_rvalid_o, ram_en_o, ram_we_o}), 32'h0);
        chk({tag, "_addr"}, 32'(ram_addr_o), 32'h0);
        chk({tag, "_data"}, ram_data_o, 32'h0);
        chk({tag, "_rdata"}, i_rdata_o | d_rdata_o, 32'h0);
    endtask

    initial begin
        logic [31:0] got;
        bit prev_d;
        for (int k = 0; k < MW; k++) ref_mem[k] = 16'(k * 7919 + 4660);
        tb_clr = 1'b1;
        i_req_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tb_clr = 1'b0;
        #1;
        chk_quiet("rst_held");
        i_req_i = 1'b0;
        reset_n = 1'b1;
        #1;
        chk_quiet("rst_released");

        do_store(17'h20, 4'h3, 32'hFFFF1234);
        do_store(17'h22, 4'h3, 32'hEEEE5678);
        do_load(1'b0, 17'h20, got);
        chk("tp_fetch20", got, 32'h56781234);
        do_load(1'b0, 17'h22, got);
        chk("tp_fetch22_lo", 32'(got[15:0]), 32'h5678);

        do_store(17'h40, 4'hF, 32'hDEADBEEF);
        chk("tp_beef", 32'(mem[16'h20]), 32'hBEEF);
        chk("tp_dead", 32'(mem[16'h21]), 32'hDEAD);
        do_store(17'h40, 4'h4, 32'h00AA0000);
        do_load(1'b1, 17'h40, got);
        chk("tp_rmw_load", got, 32'hDEAABEEF);
        do_store(17'h41, 4'h6, 32'h00123400);
        do_load(1'b1, 17'h40, got);

        do_store(17'h1FFFE, 4'hF, 32'h13572468);
        chk("wrap_hi_at_0", 32'(mem[0]), 32'h1357);
        chk("wrap_lo_at_top", 32'(mem[16'hFFFF]), 32'h2468);
        do_store(17'h60, 4'h0, 32'hFFFFFFFF);
        do_store(17'h1FFFE, 4'hE, 32'hA1B2C3D4);

        // Fresh reset so the first tie sees the pointer at its reset value.
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        i_req_i = 1'b1; i_addr_i = 17'h20;
        d_req_i = 1'b1; d_we_i = 1'b0; d_addr_i = 17'h40;
        prev_d = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bit exp_d;
            exp_d = RR ? (c % 2 == 1) : 1'b1;
            if (c == 4) begin i_req_i = 1'b0; d_req_i = 1'b0; end
            #1;
            if (c < 4) chk("tie_gnt", 32'({i_gnt_o, d_gnt_o}), exp_d ? 32'h1 : 32'h2);
            if (c > 0) begin
                chk("tie_rvalid", 32'({i_rvalid_o, d_rvalid_o}), prev_d ? 32'h1 : 32'h2);
                chk("tie_rdata", prev_d ? d_rdata_o : i_rdata_o, prev_d ? ref_rd(17'h40) : ref_rd(17'h20));
            end
            prev_d = exp_d;
            @(posedge clk); #1;
        end

        for (int n = 0; n < 200; n++) begin
            logic [AW:0] a;
            int op;
            op = $urandom_range(0, 3);
            a = 17'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) a = 17'h1FFFE - 17'($urandom_range(0, 3));
            if (op == 0) do_load(1'b0, a, got);
            else if (op == 1) do_load(1'b1, a, got);
            else do_store(a, 4'($urandom), $urandom);
        end

        // Reset while the high halfword of a full store is still pending.
        d_req_i = 1'b1; d_we_i = 1'b1; d_be_i = 4'hF; d_addr_i = 17'h300; d_wdata_i = 32'hCAFEF00D;
        #1;
        chk("wrhi_gnt", 32'(d_gnt_o), 32'h1);
        @(posedge clk); #1;
        d_req_i = 1'b0;
        i_req_i = 1'b1; i_addr_i = 17'h300;
        #1;
        chk("wrhi_active", 32'({ram_en_o, ram_we_o, ram_addr_o}), 32'({2'b11, 16'h181}));
        reset_n = 1'b0;
        #1;
        chk_quiet("wrhi_reset");
        ref_mem[16'h180] = 16'hF00D;
        @(posedge clk); #1;
        chk("wrhi_lo_written", 32'(mem[16'h180]), 32'hF00D);
        chk("wrhi_hi_untouched", 32'(mem[16'h181]), 32'(ref_mem[16'h181]));
        reset_n = 1'b1;
        #1;
        chk("post_rst_gnt", 32'({i_gnt_o, d_gnt_o}), 32'h2);
        @(posedge clk); #1;
        i_req_i = 1'b0;
        #1;
        chk("post_rst_rvalid", 32'({i_rvalid_o, d_rvalid_o}), 32'h2);
        chk("post_rst_rdata", i_rdata_o, ref_rd(17'h300));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram16_port_ctrl.md
# ram16_port_ctrl

Dual-requester controller for the simulation 16-bit-word RAM: arbitrates an instruction fetch port and a data load/store port onto the RAM's single `en/we/addr` port. Reads return 32 bits, as two consecutive halfwords, from any halfword-aligned address. Writes are decomposed into one or two 16-bit RAM writes. Partial-halfword (byte) stores are performed as a read-modify-write sequence. Sits between the RS5 core's memory interfaces and the RAM in the simulation testbench.

## Interface
Parameters:
- `MEM_WIDTH`, 65536: RAM depth in 16-bit words; `RAM_AW = $clog2(MEM_WIDTH)`.

Ports:
- `clk`  in  1  sole clock; all state on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `i_req_i`  in  1  instruction read request
- `i_addr_i`  in  RAM_AW+1  instruction byte address; bit 0 ignored
- `i_gnt_o`  out  1  instruction request accepted this cycle
- `i_rvalid_o`  out  1  instruction read data valid
- `i_rdata_o`  out  32  instruction read data
- `d_req_i`  in  1  data request
- `d_we_i`  in  1  1 = store, 0 = load
- `d_be_i`  in  4  store byte enables, relative to the 32-bit window at the halfword address
- `d_addr_i`  in  RAM_AW+1  data byte address; bit 0 ignored
- `d_wdata_i`  in  32  store data
- `d_gnt_o`  out  1  data request accepted this cycle
- `d_rvalid_o`  out  1  load data valid, or store complete
- `d_rdata_o`  out  32  load data
- `ram_en_o`, `ram_we_o`  out  1 each  RAM enable and write enable
- `ram_addr_o`  out  RAM_AW  RAM halfword index
- `ram_data_o`  out  32  write data; [31:16] always 0
- `ram_data_a_i`, `ram_data_b_i`  in  32  RAM outputs RAM[addr] and RAM[addr+1]; only [15:0] used

## Operation
- Halfword index: `hw = addr[RAM_AW:1]`.
- States: `IDLE`, `RMW_MERGE`, `WR_HI`.
  - Requests are granted only in `IDLE`.
  - Grants are combinational; at most one grant per cycle.
- Request data (`d_we_i`, `d_be_i`, `d_addr_i`, `d_wdata_i`) is captured into registers on grant. Requesters may change inputs after the grant.
- Load or fetch:
  - Grant cycle: `ram_en_o=1`, `ram_we_o=0`, `ram_addr_o=hw`.
  - Next cycle: `rvalid=1` on the granted port, with `rdata={b[15:0],a[15:0]}`.
  - State stays `IDLE`.
- Store with `be` in {1111, 0011, 1100}:
  - Grant cycle writes the first needed halfword: low = `wdata[15:0]` at `hw`, or high = `wdata[31:16]` at `hw+1`.
  - `be=1111`: go to `WR_HI`, which writes the high halfword next cycle.
- Any other nonzero `be` (partial halfword):
  - Grant cycle: read at `hw`; go to `RMW_MERGE`.
  - `RMW_MERGE`: merge enabled bytes of `wdata` over `{b,a}`; register the merged high halfword.
  - `RMW_MERGE` then writes merged low at `hw` if `be[1:0]!=0`, otherwise merged high at `hw+1`.
  - If both halves are needed, go to `WR_HI`.
- Store with `be=0000`: granted, no RAM access, `d_rvalid_o` pulses next cycle.
- `d_rvalid_o` for a store pulses the cycle after the last RAM write. `d_rdata_o` is 0 for stores.
- `hw+1` wraps modulo `MEM_WIDTH`. A high-halfword write at `hw=MEM_WIDTH-1` goes to index 0.
- Arbitration on a simultaneous `i_req_i` and `d_req_i` in `IDLE` is set by Configuration.

## Timing
- Reset values:
  - State `IDLE`; priority pointer = instruction.
  - All `*_gnt_o`, `*_rvalid_o`, `ram_en_o`, `ram_we_o` = 0.
  - `ram_addr_o=0`, `ram_data_o=0`.
  - `rdata` outputs are forced to 0 whenever the matching `rvalid` is low.
- Read latency is 1 cycle. Back-to-back reads on either port sustain 1 per cycle.
- Store occupancy:
  - 1 cycle for a single halfword.
  - 2 cycles for `be=1111`.
  - 2 cycles for partial `be` touching one half.
  - 3 cycles for partial `be` touching both halves.
  - No grants are issued during occupancy.
- A request not granted must be held by the requester until granted.
- Reset asserted mid-store aborts immediately. A half-completed `1111` or RMW store may leave only the low halfword written; no `rvalid` follows.

## Configuration
- `RAM16_ARB_RR_EN` defined: round-robin on ties.
  - The pointer flips to the other port after every grant.
  - The first tie after reset goes to instruction.
- `RAM16_ARB_RR_EN` undefined: fixed priority; data always wins ties. The pointer register is not built.

## Test plan
- Write 0x1234 at index 0x10 and 0x5678 at index 0x11 via stores; fetch at byte address 0x20 -> `i_rvalid_o` next cycle, `i_rdata_o=0x56781234`. Fetch at byte address 0x22 -> `[15:0]=0x5678`.
- Store `be=1111`, `wdata=0xDEADBEEF` at 0x40 -> `ram_we_o` high for 2 cycles (index 0x20 gets 0xBEEF, 0x21 gets 0xDEAD); `d_rvalid_o` 2 cycles after grant; no grants meanwhile.
- Memory at 0x40 = 0xDEADBEEF; store `be=0100`, `wdata=0x00AA0000` -> read-then-write of index 0x21 only; load returns 0xDEAABEEF; occupancy 2 cycles.
- `i_req_i` and `d_req_i` held high together for 4 cycles with loads -> with the macro, grants alternate I,D,I,D; without it, D on all 4.
- Store `be=1111` at `hw=MEM_WIDTH-1` -> high halfword written to index 0. Store `be=0000` -> `d_rvalid_o` after 1 cycle, `ram_en_o` stays 0.
- Assert `reset_n` low in `WR_HI` -> all outputs 0 immediately; after release, state is `IDLE` and a fetch is granted on the first request.
